// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage with a one-entry holding buffer for gapless
// back-to-back frames. A word is accepted on par_valid & par_ready and shifted
// out one bit per ser_valid & ser_ready transfer, with frame_start/frame_last
// markers decoded from the bit counter.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;

    logic accept;
    logic xfer;
    logic at_last;

    // Move the shifter one position toward the output end, zero fill.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    assign par_ready   = ~hold_full_q;
    assign ser_valid   = (state_q == SHIFT);
    assign ser_out     = ser_valid & (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
    assign frame_start = ser_valid & (cnt_q == '0);
    assign frame_last  = ser_valid & (cnt_q == CNT_LAST);
    assign busy        = (state_q == SHIFT) | hold_full_q;

    assign accept  = par_valid & par_ready;
    assign xfer    = ser_valid & ser_ready;
    assign at_last = (cnt_q == CNT_LAST);

    // Next-state logic: load from IDLE, shift per transfer, and at frame end
    // reload from the holding buffer, bypass a fresh word, or go idle.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = par_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && at_last) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sh_d        = hold_data_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sh_d = par_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        sh_d  = shift_once(sh_q);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (accept) begin
                        hold_data_d = par_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an 8-bit MSB-first instance and a
// 5-bit LSB-first instance. Each table row gives the inputs for one cycle and
// the outputs expected during that cycle:
// exp = {ser_valid, ser_out, frame_start, frame_last, par_ready, busy}.
module tb_piso_serializer;

    logic clk;
    logic rst_n;

    logic [7:0] pd8;
    logic       pv8, sr8;
    logic       pr8, so8, sv8, fs8, fl8, busy8;

    logic [4:0] pd5;
    logic       pv5, sr5;
    logic       pr5, so5, sv5, fs5, fl5, busy5;

    int checks;
    int errors;

    typedef struct {
        bit         dut;  // 0 = 8-bit MSB-first, 1 = 5-bit LSB-first
        logic       pv;
        logic [7:0] pd;
        logic       sr;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .par_data(pd8), .par_valid(pv8),
        .par_ready(pr8), .ser_out(so8), .ser_valid(sv8), .ser_ready(sr8),
        .frame_start(fs8), .frame_last(fl8), .busy(busy8)
    );

    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) dut5 (
        .clk(clk), .rst_n(rst_n), .par_data(pd5), .par_valid(pv5),
        .par_ready(pr5), .ser_out(so5), .ser_valid(sv5), .ser_ready(sr5),
        .frame_start(fs5), .frame_last(fl5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] out8();
        return {sv8, so8, fs8, fl8, pr8, busy8};
    endfunction

    function automatic logic [5:0] out5();
        return {sv5, so5, fs5, fl5, pr5, busy5};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b (sv,so,fs,fl,pr,busy)", name, act, exp);
        end
    endtask

    function automatic void add(input bit d, input logic pv, input logic [7:0] pd,
                                input logic sr, input logic [5:0] e);
        tbl.push_back('{dut: d, pv: pv, pd: pd, sr: sr, exp: e});
    endfunction

    // One cycle: check outputs after the falling edge, then drive inputs.
    task automatic step(input string name, input bit d, input logic pv,
                        input logic [7:0] pd, input logic sr, input logic [5:0] e);
        @(negedge clk);
        #1;
        if (d == 1'b0) begin
            chk(name, out8(), e);
            pv8 = pv; pd8 = pd; sr8 = sr;
            pv5 = 1'b0; sr5 = 1'b1;
        end else begin
            chk(name, out5(), e);
            pv5 = pv; pd5 = pd[4:0]; sr5 = sr;
            pv8 = 1'b0; sr8 = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        pv8 = 1'b0; pd8 = '0; sr8 = 1'b1;
        pv5 = 1'b0; pd5 = '0; sr5 = 1'b1;

        // Reset state before any clock edge
        #2;
        chk("reset8", out8(), 6'b000010);
        chk("reset5", out5(), 6'b000010);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame 0xA5, MSB first
        add(0, 1, 8'hA5, 1, 6'b000010);
        add(0, 0, 8'h00, 1, 6'b111011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b110111);
        add(0, 0, 8'h00, 1, 6'b000010);
        // Back-to-back 0xA5 then 0x3C through the holding buffer
        add(0, 1, 8'hA5, 1, 6'b000010);
        add(0, 1, 8'h3C, 1, 6'b111011);
        add(0, 0, 8'h00, 1, 6'b100001);
        add(0, 0, 8'h00, 1, 6'b110001);
        add(0, 0, 8'h00, 1, 6'b100001);
        add(0, 0, 8'h00, 1, 6'b100001);
        add(0, 0, 8'h00, 1, 6'b110001);
        add(0, 0, 8'h00, 1, 6'b100001);
        add(0, 0, 8'h00, 1, 6'b110101);
        add(0, 0, 8'h00, 1, 6'b101011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b100111);
        add(0, 0, 8'h00, 1, 6'b000010);
        // Bypass: 0xFF presented exactly on the frame_last transfer of 0x00
        add(0, 1, 8'h00, 1, 6'b000010);
        add(0, 0, 8'h00, 1, 6'b101011);
        for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 1, 8'hFF, 1, 6'b100111);
        add(0, 0, 8'h00, 1, 6'b111011);
        for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b110111);
        add(0, 0, 8'h00, 1, 6'b000010);
        // Stalls: 3 cycles at bit 4, 2 cycles at frame_last
        add(0, 1, 8'hA5, 1, 6'b000010);
        add(0, 0, 8'h00, 1, 6'b111011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 0, 6'b100011);
        add(0, 0, 8'h00, 0, 6'b100011);
        add(0, 0, 8'h00, 0, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 1, 6'b110011);
        add(0, 0, 8'h00, 1, 6'b100011);
        add(0, 0, 8'h00, 0, 6'b110111);
        add(0, 0, 8'h00, 0, 6'b110111);
        add(0, 0, 8'h00, 1, 6'b110111);
        add(0, 0, 8'h00, 1, 6'b000010);
        // WIDTH=5 LSB first: 5'b10110 -> 0,1,1,0,1, then 5'b00011 -> 1,1,0,0,0
        add(1, 1, 8'h16, 1, 6'b000010);
        add(1, 0, 8'h00, 1, 6'b101011);
        add(1, 0, 8'h00, 1, 6'b110011);
        add(1, 0, 8'h00, 1, 6'b110011);
        add(1, 0, 8'h00, 1, 6'b100011);
        add(1, 0, 8'h00, 1, 6'b110111);
        add(1, 1, 8'h03, 1, 6'b000010);
        add(1, 0, 8'h00, 1, 6'b111011);
        add(1, 0, 8'h00, 1, 6'b110011);
        add(1, 0, 8'h00, 1, 6'b100011);
        add(1, 0, 8'h00, 1, 6'b100011);
        add(1, 0, 8'h00, 1, 6'b100111);
        add(1, 0, 8'h00, 1, 6'b000010);

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].dut, tbl[i].pv, tbl[i].pd,
                 tbl[i].sr, tbl[i].exp);
        end

        // Reset mid-frame: 0xA5 shifting with 0x3C held, after 3 bits
        step("rst_c0", 0, 1, 8'hA5, 1, 6'b000010);
        step("rst_c1", 0, 1, 8'h3C, 1, 6'b111011);
        step("rst_c2", 0, 0, 8'h00, 1, 6'b100001);
        step("rst_c3", 0, 0, 8'h00, 1, 6'b110001);
        step("rst_c4", 0, 0, 8'h00, 1, 6'b100001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", out8(), 6'b000010);
        @(posedge clk);
        #1;
        chk("rst_held", out8(), 6'b000010);
        rst_n = 1'b1;
        // New word 0x81 after release
        step("post_c0", 0, 1, 8'h81, 1, 6'b000010);
        step("post_c1", 0, 0, 8'h00, 1, 6'b111011);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("post_z%0d", i), 0, 0, 8'h00, 1, 6'b100011);
        end
        step("post_c8", 0, 0, 8'h00, 1, 6'b110111);
        step("post_c9", 0, 0, 8'h00, 1, 6'b000010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage built on the team's D flip-flop register cells. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per transfer, with frame markers. A one-entry holding buffer allows gapless back-to-back frames. It sits directly upstream of the serial consumer (line driver or SIPO receiver), which can stall it with ser_ready.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
par_data  input  WIDTH  parallel word.
par_valid  input  1  par_data is valid.
par_ready  output  1  block can accept a word; a word is accepted when par_valid & par_ready.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out holds a valid bit.
ser_ready  input  1  consumer takes the bit; a bit is transferred when ser_valid & ser_ready.
frame_start  output  1  current bit is bit 0 of a frame.
frame_last  output  1  current bit is the final bit of a frame.
busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- State elements: shifter sh[WIDTH-1:0], bit counter cnt[$clog2(WIDTH)-1:0], holding register hold_data plus flag hold_full, FSM state {IDLE, SHIFT}.
- Reset (rst_n low, immediate, no clock needed): state=IDLE, sh=0, cnt=0, hold_data=0, hold_full=0.
  - Resulting outputs: ser_valid=0, ser_out=0, frame_start=0, frame_last=0, busy=0, par_ready=1.
  - Reset mid-frame aborts the frame; the partial word and the held word are discarded. After rst_n rises, the first clock edge behaves as IDLE.
- Output decode (from flops, no registered delay):
  - par_ready = ~hold_full.
  - ser_valid = (state==SHIFT).
  - ser_out = sh[WIDTH-1] if MSB_FIRST else sh[0], gated to 0 when not ser_valid.
  - frame_start = ser_valid & (cnt==0).
  - frame_last = ser_valid & (cnt==WIDTH-1).
  - busy = (state==SHIFT) | hold_full.
- IDLE:
  - On accept: sh<=par_data, cnt<=0, state<=SHIFT. The first bit is valid the cycle after the accept edge (latency 1).
  - The holding buffer is never used from IDLE.
- SHIFT, no transfer (ser_ready=0): sh, cnt and state hold. An accept in this cycle (hold empty) writes hold_data and sets hold_full=1.
- SHIFT, transfer with cnt<WIDTH-1:
  - Shift toward the output end: MSB_FIRST shifts left with 0 fill; otherwise shifts right with 0 fill.
  - cnt<=cnt+1.
  - Accept into the holding buffer as above.
- SHIFT, transfer with cnt==WIDTH-1 (frame end), in priority order:
  - (a) hold_full=1: sh<=hold_data, hold_full<=0, cnt<=0, stay SHIFT. par_ready was 0, so no simultaneous accept is possible.
  - (b) hold empty and an accept in the same cycle: sh<=par_data directly (bypass), cnt<=0, stay SHIFT.
  - (c) otherwise: state<=IDLE, cnt<=0.
  - Cases (a) and (b) give zero-gap frames: frame_last on cycle N, frame_start on cycle N+1.
- Stall at frame end (ser_ready=0 while frame_last=1): nothing changes; the holding buffer may still fill.
- Backpressure: par_ready stays 0 while hold_full=1. Upstream must hold par_data and par_valid stable.
- Output constraint: ser_out, frame_* and ser_valid must be stable while ser_valid=1 and ser_ready=0.
- cnt never exceeds WIDTH-1. Non-power-of-2 WIDTH must work.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, ser_ready=1, single accept of 0xA5 -> ser_valid high for exactly 8 cycles starting 1 cycle after accept; ser_out=1,0,1,0,0,1,0,1; frame_start on bit 1 only, frame_last on bit 8 only; then IDLE, busy=0.
2. Back-to-back: 0xA5 accepted in IDLE, 0x3C presented on the next cycle -> 0x3C goes to the holding buffer; par_ready=0 until the 0xA5 frame ends; 16 contiguous valid bits 10100101 00111100; frame_start on bits 1 and 9.
3. Bypass: hold empty, par_valid with 0xFF asserted exactly on the frame_last transfer cycle of 0x00 -> accepted with no gap; 8 zeros followed by 8 ones, continuous ser_valid.
4. Stall: during 0xA5, ser_ready=0 for 3 cycles at bit 4 and for 2 cycles at frame_last -> outputs frozen during the stalls; bit sequence unchanged; frame markers appear once each.
5. Reset mid-frame: rst_n low asynchronously (between edges) after 3 bits of 0xA5 with 0x3C held -> ser_valid, busy and frame_* drop to 0 immediately; par_ready=1. After release, a new word 0x81 serializes cleanly from bit 1.
6. MSB_FIRST=0, WIDTH=5, word 5'b10110 -> ser_out=0,1,1,0,1; frame_last on the 5th bit; cnt wraps to 0.
